// File: rtl/bbs_step_back.sv
// bbs_step_back: recovers the BBS predecessor x from s = x^2 mod MOD
// as x = s^EXP mod MOD. Option macro: BBS_STEP_BACK_CONST_TIME_EN.
module bbs_step_back #(
    parameter int SIZE     = 16,
    parameter int MOD      = 40633,
    parameter int EXP      = 5029,
    parameter int EXP_BITS = 13
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [SIZE-1:0] s_in,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [SIZE-1:0] result
);

    localparam int CW = $clog2(SIZE);
    localparam int IW = $clog2(EXP_BITS);

    localparam logic [SIZE:0]     MOD_W    = (SIZE+1)'(MOD);
    localparam logic [EXP_BITS-1:0] EXP_W  = EXP_BITS'(EXP);
    localparam logic [CW-1:0]     CNT_LAST = CW'(SIZE-1);
    localparam logic [IW-1:0]     IDX_TOP  = IW'(EXP_BITS-1);

    typedef enum logic [1:0] {
        IDLE,
        SQR,
        MUL,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SIZE-1:0] acc;
    logic [SIZE-1:0] base;
    logic [SIZE:0]   t;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic            err_q;
    logic [SIZE-1:0] result_q;

    logic [SIZE:0]   t_dbl;
    logic [SIZE:0]   t_red;
    logic [SIZE:0]   t_add;
    logic [SIZE:0]   t_nxt;
    logic [SIZE:0]   addend;
    logic [CW-1:0]   bsel;
    logic            mbit;

    logic            last;
    logic            ebit;
    logic            idx_zero;
    logic            too_big;
    logic            acc_we;
    logic            idx_dec;
    logic            accept;

    assign last     = (cnt == CNT_LAST);
    assign ebit     = EXP_W[idx];
    assign idx_zero = (idx == '0);
    assign too_big  = ({1'b0, s_in} >= MOD_W);
    assign accept   = (state == IDLE) && start;

    assign err      = err_q;
    assign result   = result_q;

    // One shift-add modmul step: multiplier is always acc, scanned MSB first.
    // Every intermediate stays below 2*MOD, so SIZE+1 bits never overflow.
    always_comb begin
        bsel   = CNT_LAST - cnt;
        mbit   = acc[bsel];
        addend = {1'b0, (state == MUL) ? base : acc};
        t_dbl  = t + t;
        t_red  = (t_dbl >= MOD_W) ? (t_dbl - MOD_W) : t_dbl;
        t_add  = mbit ? (t_red + addend) : t_red;
        t_nxt  = (t_add >= MOD_W) ? (t_add - MOD_W) : t_add;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode, status outputs and datapath strobes.
    always_comb begin
        state_nxt = state;
        acc_we    = 1'b0;
        idx_dec   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = too_big ? DONE : SQR;
                end
            end
            SQR: begin
                busy = 1'b1;
                if (last) begin
                    acc_we = 1'b1;
`ifdef BBS_STEP_BACK_CONST_TIME_EN
                    state_nxt = MUL;
`else
                    if (ebit) begin
                        state_nxt = MUL;
                    end else if (!idx_zero) begin
                        idx_dec   = 1'b1;
                        state_nxt = SQR;
                    end else begin
                        state_nxt = DONE;
                    end
`endif
                end
            end
            MUL: begin
                busy = 1'b1;
                if (last) begin
                    // a product for a clear exponent bit is dropped
                    acc_we = ebit;
                    if (!idx_zero) begin
                        idx_dec   = 1'b1;
                        state_nxt = SQR;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, modmul accumulation, exponent walk and result latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            base     <= '0;
            t        <= '0;
            cnt      <= '0;
            idx      <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            base     <= s_in;
            acc      <= SIZE'(1);
            idx      <= IDX_TOP;
            t        <= '0;
            cnt      <= '0;
            err_q    <= too_big;
            result_q <= '0;
        end else if (busy) begin
            if (last) begin
                t   <= '0;
                cnt <= '0;
            end else begin
                t   <= t_nxt;
                cnt <= cnt + 1'b1;
            end
            if (acc_we) begin
                acc <= t_nxt[SIZE-1:0];
            end
            if (idx_dec) begin
                idx <= idx - 1'b1;
            end
            if (state_nxt == DONE) begin
                result_q <= acc_we ? t_nxt[SIZE-1:0] : acc;
            end
        end
    end

endmodule
